// File: rtl/feature_map_pingpong_buffer_if.sv
// Producer/consumer handshake bundle for the ping-pong feature-map buffer.
// With FMB_OOB_ERR_EN defined, the out-of-range error flag and counter are added.
interface feature_map_pingpong_buffer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_row;
  logic [ADDR_W-1:0] wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              wr_ready;
  logic              wr_bank_id;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic              rd_frame_done;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        frames_pending;
`ifdef FMB_OOB_ERR_EN
  logic              oob_err;
  logic [7:0]        oob_cnt;
`endif

  modport master (
    output wr_en, wr_row, wr_col, wr_data, wr_frame_done,
    output rd_en, rd_row, rd_col, rd_frame_done,
    input  wr_ready, wr_bank_id, rd_ready, rd_data, rd_valid, frames_pending
`ifdef FMB_OOB_ERR_EN
    , input oob_err, oob_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, wr_frame_done,
    input  rd_en, rd_row, rd_col, rd_frame_done,
    output wr_ready, wr_bank_id, rd_ready, rd_data, rd_valid, frames_pending
`ifdef FMB_OOB_ERR_EN
    , output oob_err, oob_cnt
`endif
  );
endinterface

// File: rtl/feature_map_pingpong_buffer.sv
// Double-buffered 2D feature-map store: producer fills one bank while the consumer reads the other.
// Optional FMB_OOB_ERR_EN adds a sticky out-of-range flag and a saturating event counter.
module feature_map_pingpong_buffer #(
  parameter int DATA_W = 128,
  parameter int ROWS   = 30,
  parameter int COLS   = 30,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  feature_map_pingpong_buffer_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [DATA_W-1:0] mem_q [2][ROWS][COLS];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic wr_ready, rd_ready, wr_in, rd_in, wr_acc, rd_acc;
  logic [RW-1:0] wr_rix, rd_rix;
  logic [CW-1:0] wr_cix, rd_cix;

  assign wr_ready = !full_q[wr_bank_q];
  assign rd_ready = full_q[rd_bank_q];
  // Range checks use the full port width so large addresses never alias into the array.
  assign wr_in  = (bus.wr_row < ROWS_A) && (bus.wr_col < COLS_A);
  assign rd_in  = (bus.rd_row < ROWS_A) && (bus.rd_col < COLS_A);
  assign wr_acc = bus.wr_en && wr_ready && wr_in;
  assign rd_acc = bus.rd_en && rd_ready && rd_in;
  assign wr_rix = bus.wr_row[RW-1:0];
  assign wr_cix = bus.wr_col[CW-1:0];
  assign rd_rix = bus.rd_row[RW-1:0];
  assign rd_cix = bus.rd_col[CW-1:0];

  assign bus.wr_ready       = wr_ready;
  assign bus.rd_ready       = rd_ready;
  assign bus.wr_bank_id     = wr_bank_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_bank_q][wr_rix][wr_cix] <= bus.wr_data;
  end

  // Producer and consumer hand-offs always hit different banks, so both may apply together.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_acc;
    rd_data_d  = '0;
    if (rd_acc) rd_data_d = mem_q[rd_bank_q][rd_rix][rd_cix];
    if (bus.wr_frame_done && wr_ready) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (bus.rd_frame_done && rd_ready) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FMB_OOB_ERR_EN
  logic       oob_err_q, oob_err_d;
  logic [7:0] oob_cnt_q, oob_cnt_d;
  logic [1:0] oob_ev;
  logic [8:0] oob_sum;

  // A write and a read can both be out of range in one cycle; each counts.
  assign oob_ev  = {1'b0, bus.wr_en && !wr_in} + {1'b0, bus.rd_en && !rd_in};
  assign oob_sum = {1'b0, oob_cnt_q} + 9'(oob_ev);

  always_comb begin
    oob_err_d = oob_err_q || (oob_ev != 2'd0);
    oob_cnt_d = oob_sum[8] ? 8'hFF : oob_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_err_q <= 1'b0;
      oob_cnt_q <= '0;
    end else begin
      oob_err_q <= oob_err_d;
      oob_cnt_q <= oob_cnt_d;
    end
  end

  assign bus.oob_err = oob_err_q;
  assign bus.oob_cnt = oob_cnt_q;
`endif
endmodule

// File: tb/tb_feature_map_pingpong_buffer.sv
// Directed vector bench for the ping-pong feature-map buffer, plus an async mid-read reset sequence.
module tb_feature_map_pingpong_buffer;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  feature_map_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  feature_map_pingpong_buffer #(.DATA_W(DATA_W), .ROWS(30), .COLS(30), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wr, wc;
    logic [DATA_W-1:0] wd;
    logic              wfd;
    logic              re;
    logic [ADDR_W-1:0] rr, rc;
    logic              rfd;
    logic              x_wrdy, x_rrdy, x_rv, x_wb;
    logic [DATA_W-1:0] x_rd;
    logic [1:0]        x_fp;
  } vec_t;

  localparam int NV = 21;
  vec_t v [NV];

  function automatic vec_t mk(logic we, int wr, int wc, logic [DATA_W-1:0] wd, logic wfd,
                              logic re, int rr, int rc, logic rfd,
                              logic x_wrdy, logic x_rrdy, logic x_rv, logic [DATA_W-1:0] x_rd,
                              logic [1:0] x_fp, logic x_wb);
    vec_t t;
    t.we = we; t.wr = ADDR_W'(wr); t.wc = ADDR_W'(wc); t.wd = wd; t.wfd = wfd;
    t.re = re; t.rr = ADDR_W'(rr); t.rc = ADDR_W'(rc); t.rfd = rfd;
    t.x_wrdy = x_wrdy; t.x_rrdy = x_rrdy; t.x_rv = x_rv; t.x_rd = x_rd;
    t.x_fp = x_fp; t.x_wb = x_wb;
    return t;
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.wr_en = 0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0; bus.wr_frame_done = 0;
    bus.rd_en = 0; bus.rd_row = '0; bus.rd_col = '0; bus.rd_frame_done = 0;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, ".wr_ready"}, DATA_W'(bus.wr_ready), 1);
    chk({tag, ".rd_ready"}, DATA_W'(bus.rd_ready), 0);
    chk({tag, ".rd_valid"}, DATA_W'(bus.rd_valid), 0);
    chk({tag, ".rd_data"}, bus.rd_data, '0);
    chk({tag, ".frames_pending"}, DATA_W'(bus.frames_pending), 0);
    chk({tag, ".wr_bank_id"}, DATA_W'(bus.wr_bank_id), 0);
`ifdef FMB_OOB_ERR_EN
    chk({tag, ".oob_err"}, DATA_W'(bus.oob_err), 0);
    chk({tag, ".oob_cnt"}, DATA_W'(bus.oob_cnt), 0);
`endif
  endtask

  logic [DATA_W-1:0] a5;
  logic [DATA_W-1:0] d1, d2, d3, d7, d9;

  initial begin
    a5 = {16{8'hA5}};
    d1 = DATA_W'(1); d2 = DATA_W'(2); d3 = DATA_W'(3); d7 = DATA_W'(7); d9 = DATA_W'(9);
    //          we wr wc wd  wfd re rr rc rfd   wrdy rrdy rv rd  fp wb
    v[0]  = mk(0, 0, 0, '0, 0,  0, 0, 0, 0,    1, 0, 0, '0, 0, 0);
    v[1]  = mk(1, 3, 4, a5, 0,  0, 0, 0, 0,    1, 0, 0, '0, 0, 0);
    v[2]  = mk(0, 0, 0, '0, 1,  0, 0, 0, 0,    1, 1, 0, '0, 1, 1);
    v[3]  = mk(0, 0, 0, '0, 0,  1, 3, 4, 0,    1, 1, 1, a5, 1, 1);
    v[4]  = mk(0, 0, 0, '0, 0,  1, 30, 0, 0,   1, 1, 0, '0, 1, 1);
    v[5]  = mk(0, 0, 0, '0, 0,  1, 0, 30, 0,   1, 1, 0, '0, 1, 1);
    v[6]  = mk(0, 0, 0, '0, 0,  0, 0, 0, 1,    1, 0, 0, '0, 0, 1);
    v[7]  = mk(1, 0, 0, d1, 0,  0, 0, 0, 0,    1, 0, 0, '0, 0, 1);
    v[8]  = mk(0, 0, 0, '0, 1,  0, 0, 0, 0,    1, 1, 0, '0, 1, 0);
    v[9]  = mk(1, 0, 0, d2, 1,  0, 0, 0, 0,    0, 1, 0, '0, 2, 1);
    v[10] = mk(1, 0, 0, d3, 1,  0, 0, 0, 0,    0, 1, 0, '0, 2, 1);
    v[11] = mk(0, 0, 0, '0, 0,  1, 0, 0, 1,    1, 1, 1, d1, 1, 1);
    v[12] = mk(0, 0, 0, '0, 0,  1, 0, 0, 0,    1, 1, 1, d2, 1, 1);
    v[13] = mk(1, 5, 5, d7, 1,  1, 0, 0, 1,    1, 1, 1, d2, 1, 0);
    v[14] = mk(0, 0, 0, '0, 0,  1, 5, 5, 0,    1, 1, 1, d7, 1, 0);
    v[15] = mk(0, 0, 0, '0, 0,  1, 0, 0, 0,    1, 1, 1, d1, 1, 0);
    v[16] = mk(1, 29, 29, d9, 1, 0, 0, 0, 0,   0, 1, 0, '0, 2, 1);
    v[17] = mk(0, 0, 0, '0, 0,  0, 0, 0, 1,    1, 1, 0, '0, 1, 1);
    v[18] = mk(0, 0, 0, '0, 0,  1, 29, 29, 0,  1, 1, 1, d9, 1, 1);
    v[19] = mk(1, 30, 0, d3, 0, 1, 0, 30, 0,   1, 1, 0, '0, 1, 1);
    v[20] = mk(0, 0, 0, '0, 1,  0, 0, 0, 0,    0, 1, 0, '0, 2, 0);

    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.wr_en = v[i].we; bus.wr_row = v[i].wr; bus.wr_col = v[i].wc;
      bus.wr_data = v[i].wd; bus.wr_frame_done = v[i].wfd;
      bus.rd_en = v[i].re; bus.rd_row = v[i].rr; bus.rd_col = v[i].rc;
      bus.rd_frame_done = v[i].rfd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.wr_ready", i), DATA_W'(bus.wr_ready), DATA_W'(v[i].x_wrdy));
      chk($sformatf("v%0d.rd_ready", i), DATA_W'(bus.rd_ready), DATA_W'(v[i].x_rrdy));
      chk($sformatf("v%0d.rd_valid", i), DATA_W'(bus.rd_valid), DATA_W'(v[i].x_rv));
      chk($sformatf("v%0d.rd_data", i), bus.rd_data, v[i].x_rd);
      chk($sformatf("v%0d.frames_pending", i), DATA_W'(bus.frames_pending), DATA_W'(v[i].x_fp));
      chk($sformatf("v%0d.wr_bank_id", i), DATA_W'(bus.wr_bank_id), DATA_W'(v[i].x_wb));
`ifdef FMB_OOB_ERR_EN
      if (i == 3) chk("oob_err_before", DATA_W'(bus.oob_err), 0);
      if (i == 5) begin
        chk("oob_err_after_reads", DATA_W'(bus.oob_err), 1);
        chk("oob_cnt_after_reads", DATA_W'(bus.oob_cnt), 2);
      end
      if (i == 19) chk("oob_cnt_dual", DATA_W'(bus.oob_cnt), 4);
`endif
    end

    // Two banks full, read in flight, then reset asserted between clock edges.
    drive_idle();
    bus.rd_en = 1; bus.rd_row = '0; bus.rd_col = '0;
    @(posedge clk);
    #1;
    chk("preRst.rd_valid", DATA_W'(bus.rd_valid), 1);
    chk("preRst.rd_data", bus.rd_data, d2);
    chk("preRst.frames_pending", DATA_W'(bus.frames_pending), 2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    check_reset_values("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/feature_map_pingpong_buffer.md
Name: feature_map_pingpong_buffer

Overview:
- Parametrised, double-buffered (ping-pong) 2D feature-map store for conv-layer results.
- The producer (conv/activation stage) fills one bank by row/col address while the consumer (next layer / pooling) reads the other.
- Banks are handed off via frame-done handshakes.
- Read path is registered: 1-cycle latency with a valid flag.

Parameters:
- DATA_W, 128, width of one stored pixel vector (all channels packed).
- ROWS, 30, feature-map height.
- COLS, 30, feature-map width.
- ADDR_W, 16, width of row/col address ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wr_row  in  ADDR_W  write row address
- wr_col  in  ADDR_W  write column address
- wr_data  in  DATA_W  write data
- wr_frame_done  in  1  producer finished current bank
- wr_ready  out  1  a write bank is available (bank not full)
- wr_bank_id  out  1  bank currently owned by the producer
- rd_en  in  1  read request
- rd_row  in  ADDR_W  read row address
- rd_col  in  ADDR_W  read column address
- rd_frame_done  in  1  consumer releases current bank
- rd_ready  out  1  a full bank is available for reading
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid this cycle
- frames_pending  out  2  number of full banks (0..2)

Behaviour:
- Storage: 2 banks x ROWS x COLS x DATA_W. Contents are not reset.
- State: full[1:0], wr_bank, rd_bank.
- Reset values: full=0, wr_bank=0, rd_bank=0, rd_data=0, rd_valid=0.
  - Hence wr_ready=1, rd_ready=0, frames_pending=0 out of reset.
- wr_ready = !full[wr_bank] (combinational). rd_ready = full[rd_bank] (combinational).
- frames_pending = full[0]+full[1] (combinational).
- Write accept: wr_en && wr_ready && wr_row<ROWS && wr_col<COLS.
  - Accepted write updates bank wr_bank at the next edge.
  - Not accepted: storage unchanged.
- wr_frame_done && wr_ready: full[wr_bank]<=1, wr_bank toggles.
  - A write in the same cycle lands in the old bank before the toggle.
  - wr_frame_done while !wr_ready is ignored.
- Read accept: rd_en && rd_ready && in-range.
  - Next cycle: rd_valid=1, rd_data = bank[rd_bank][rd_row][rd_col].
- Any other cycle (no read, not ready, or out-of-range): next cycle rd_valid=0, rd_data=0.
- rd_frame_done && rd_ready: full[rd_bank]<=0, rd_bank toggles.
  - A read in the same cycle uses the old bank; its data still returns next cycle.
  - rd_frame_done while !rd_ready is ignored.
- Simultaneous wr_frame_done and rd_frame_done: both take effect.
  - They always target different banks, because the write bank is never full while the read bank is.
- Write to bank B, then rd_frame_done of B: B's old data persists until overwritten. No clearing.
- Read-during-write to the same address: impossible across banks. Within a bank, the producer cannot write a full bank.
- Reset mid-frame: all handshake state returns to reset values. The partially written bank is discarded logically; its memory contents are left undefined.
- Address compare uses full ADDR_W width. No wrap or truncation; out-of-range is dropped.

Optional Feature:
- Macro FMB_OOB_ERR_EN.
- Defined:
  - Adds output oob_err (1 bit), reset 0.
  - Set sticky on any out-of-range wr_en or rd_en (ready or not). Cleared only by rst.
  - Adds output oob_cnt (8 bits, saturating at 255) counting such events.
- Undefined: ports absent; out-of-range accesses are silently dropped as above.

Test Plan:
- Reset, idle -> wr_ready=1, rd_ready=0, rd_valid=0, rd_data=0, frames_pending=0.
- Write 0xA5..A5 at (3,4) into bank 0, pulse wr_frame_done; read (3,4) -> next cycle rd_valid=1, rd_data=0xA5..A5, wr_bank_id=1, frames_pending=1.
- Fill both banks (value 1 in bank 0, 2 in bank 1) without reading -> wr_ready=0, frames_pending=2; a third write to (0,0) is dropped; read (0,0) returns 1, then after rd_frame_done returns 2.
- Same-cycle wr_frame_done (bank 1) and rd_frame_done (bank 0) with frames_pending=1 -> next cycle full={1,0}→ bank1 full, bank0 empty, frames_pending=1, wr_ready=1.
- Read (30,0) and (0,30) while rd_ready=1 -> rd_valid=0, rd_data=0; with FMB_OOB_ERR_EN, oob_err=1 and oob_cnt=2.
- Assert rst while frames_pending=2 and mid-read -> outputs immediately return to reset values, rd_valid=0 without waiting for a clock edge.
